counter_ctrl: RTL

//  Parametrised up/down counter controller: 5-state mode FSM plus an integrated WIDTH-bit counter.

---
 rtl/counter_ctrl_pkg.sv | 25 ++
 rtl/cmd_edge_detect.sv | 23 ++
 rtl/counter_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter controller: FSM state encodings, command codes
// and the {inc,set} command decode helper.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP   = 3'd1,
    SETM = 3'd2,
    STEP = 3'd3,
    DOWN = 3'd4
  } state_t;

  // Command codes are the raw {inc,set} pair.
  typedef enum logic [1:0] {
    C_NONE = 2'b00,
    C_SET  = 2'b01,
    C_INC  = 2'b10,
    C_BOTH = 2'b11
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic inc, input logic set);
    return cmd_t'({inc, set});
  endfunction

endpackage

// File: rtl/cmd_edge_detect.sv
// Edge qualifier for the {inc,set} command: a command is passed through only
// in the cycle it first differs from the previous sample and is non-zero.
module cmd_edge_detect
  import counter_ctrl_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  cmd_t i_cmd,
  output cmd_t o_cmd
);

  cmd_t r_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_prev <= C_NONE;
    else     r_prev <= i_cmd;
  end

  assign o_cmd = ((i_cmd != r_prev) && (i_cmd != C_NONE)) ? i_cmd : C_NONE;

endmodule

// File: rtl/counter_ctrl.sv
// Up/down counter controller: 5-state mode FSM driving a bounded WIDTH-bit counter.
// Define COUNTER_CTRL_EDGE_EN to edge-qualify the {inc,set} commands.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
  parameter bit          WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             up,
  output logic             enable,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  cmd_t             w_raw_cmd;
  cmd_t             w_cmd;

  assign w_raw_cmd = decode_cmd(inc, set);

`ifdef COUNTER_CTRL_EDGE_EN
  cmd_edge_detect u_edge (
    .clk   (clk),
    .clr   (clr),
    .i_cmd (w_raw_cmd),
    .o_cmd (w_cmd)
  );
`else
  assign w_cmd = w_raw_cmd;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // NOTE: defaults assigned first so no path through the case leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_cmd == C_INC) w_state_next = UP;
      UP:   if (w_cmd == C_SET) w_state_next = SETM;
      SETM: begin
        case (w_cmd)
          C_INC:   w_state_next = STEP;
          C_SET:   w_state_next = UP;
          C_BOTH:  w_state_next = DOWN;
          default: w_state_next = SETM;
        endcase
      end
      STEP: w_state_next = SETM;
      DOWN: begin
        case (w_cmd)
          C_SET:   w_state_next = SETM;
          C_BOTH:  w_state_next = IDLE;
          default: w_state_next = DOWN;
        endcase
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only.
  assign enable = (r_state == UP) || (r_state == STEP) || (r_state == DOWN);
  assign up     = (r_state == UP) || (r_state == STEP);
  assign state  = r_state;
  assign count  = r_count;

  always_comb begin
    w_count_next = r_count;
    if (load) begin
      w_count_next = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (enable && up) begin
      if (r_count >= MAX_C) w_count_next = WRAP ? '0 : MAX_C;
      else                  w_count_next = r_count + WIDTH'(1);
    end else if (enable) begin
      if (r_count == '0)    w_count_next = WRAP ? MAX_C : '0;
      else                  w_count_next = r_count - WIDTH'(1);
    end
  end

  assign tc = enable && ((up && (r_count == MAX_C)) || (!up && (r_count == '0)));

endmodule
